aes_round_key_store: RTL and testbench
======================================

Name: aes_round_key_store

Overview:
- Writable round-key buffer that replaces the file-initialised key ROM.
- Accepts round keys streamed in from the key-expansion logic over a valid/ready port and holds them in a register array.
- Serves keys to the addRoundKey stage by random-access read, or by an internal round sequencer running forward (encrypt) or reverse (decrypt).
- Width and depth are parametrised; default is AES-256 with 15 round keys of 128 bits.

Parameters:
- DATA_W, 128, round-key width in bits; must be a multiple of 8.
- DEPTH, 15, number of round keys stored.
- ADDR_W, 4, address/round-index width; 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- wr_valid  in  1  key-load beat valid.
- wr_ready  out  1  store can accept a load beat.
- wr_data  in  DATA_W  round key; beats arrive in round order 0..DEPTH-1.
- clear  in  1  invalidate contents, return to empty.
- rd_en  in  1  random-access read request.
- rd_addr  in  ADDR_W  round index for rd_en.
- seq_start  in  1  start a round sequence.
- seq_dir  in  1  0 = forward 0..DEPTH-1, 1 = reverse DEPTH-1..0; sampled with seq_start.
- seq_step  in  1  advance sequencer one round.
- key_out  out  DATA_W  registered key.
- key_valid  out  1  one-cycle pulse; key_out is new this cycle.
- key_round  out  ADDR_W  index of key_out.
- seq_last  out  1  high with key_valid when the final round of a sequence is delivered.
- keys_loaded  out  1  store full, reads permitted.
- rd_err  out  1  one-cycle pulse on an illegal read.
- key_err  out  1  parity error pulse; see Optional Feature.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - FSM=EMPTY, write pointer=0, sequencer idle.
  - All outputs 0, except wr_ready=1 from the first cycle after reset.
  - Array contents are not reset.
- FSM states:
  - EMPTY: wr_ready=1. An accepted beat (wr_valid & wr_ready) writes entry 0, pointer becomes 1, next state LOAD. If DEPTH=1, next state is FULL instead.
  - LOAD: wr_ready=1. Each accepted beat writes entry[ptr] and increments ptr. The beat written at ptr=DEPTH-1 moves to FULL.
  - FULL: wr_ready=0, keys_loaded=1, wr_valid ignored.
- clear: from any state, next state EMPTY, ptr=0, sequencer idle, keys_loaded=0. It has priority over a write in the same cycle; that beat is dropped and not written.
- Reads are legal only in FULL. Latency is 1 cycle: key_out, key_round and key_valid are registered together. key_out holds its last value when key_valid=0.
- Priority in one cycle: clear > seq_start > seq_step > rd_en. Lower-priority requests in that cycle are ignored, with no error.
- seq_start in FULL:
  - Sequencer pointer = 0 (seq_dir=0) or DEPTH-1 (seq_dir=1).
  - That key is delivered the next cycle.
  - seq_last=1 only if DEPTH=1.
- seq_step while active:
  - Pointer moves ±1 and the key is delivered the next cycle.
  - seq_last=1 when the delivered index is DEPTH-1 (forward) or 0 (reverse).
  - A seq_step after the last key is delivered ends the sequence: no key_valid, no error.
  - seq_step while idle is ignored.
- rd_en does not disturb sequencer state.
- rd_err (one cycle, key_valid=0, key_out unchanged) is raised for:
  - rd_en, seq_start or seq_step issued when not FULL;
  - rd_en with rd_addr >= DEPTH.
- A write to an entry and a read of that entry in the same cycle is impossible, because reads require FULL.

Optional Feature:
- Macro KEYSTORE_PARITY_EN.
- Defined:
  - One even-parity bit per byte (DATA_W/8 bits) is stored per entry, computed at write.
  - On each delivered read it is recomputed. Any mismatch pulses key_err together with key_valid; key_out is still delivered.
- Undefined: no parity storage; key_err tied to 0.

Test Plan:
- Reset, then load 15 beats with K_i = {16{8'h10+i}} and one idle wr_valid gap after beat 5 → wr_ready falls the cycle after beat 14 is accepted; keys_loaded=1; a 16th wr_valid is not accepted.
- seq_start with seq_dir=0, then 14 seq_step → key_round 0..14 and key_out=K_i, each one cycle after its request; seq_last only with round 14; a 15th seq_step gives no key_valid.
- seq_start with seq_dir=1 → rounds 14..0, seq_last with round 0. A same-cycle rd_en to addr 3 alongside seq_start is ignored.
- rd_en addr 15 → rd_err=1, key_valid=0. After clear, rd_en addr 2 → rd_err=1.
- Load 7 beats, then clear with wr_valid=1 in the same cycle → EMPTY, beat dropped. Reloading 15 beats is then required before keys_loaded=1. Assert resetn=0 mid-sequence → all outputs 0 the next cycle.
- With KEYSTORE_PARITY_EN: load, deposit a single-bit flip in entry 3, rd_en addr 3 → key_valid=1 and key_err=1. Reading entry 4 → key_err=0.

Source files
------------

// File: rtl/aes_round_key_store.sv
// aes_round_key_store
//   Writable round-key buffer. Round keys stream in over a valid/ready load
//   port in round order and are held in a register array. Keys are served by
//   random-access read or by an internal round sequencer (forward/reverse).
//
// Optional build macro: KEYSTORE_PARITY_EN
//   Defined   : one even-parity bit per byte stored with each entry, checked
//               on every delivered read; a mismatch pulses key_err.
//   Undefined : no parity storage, key_err tied low.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   wr_valid/ready/data key load beats, round order 0..DEPTH-1
//   clear              invalidate contents, back to EMPTY
//   rd_en, rd_addr     random-access read request
//   seq_start, seq_dir start a round sequence (0 fwd, 1 rev)
//   seq_step           advance the sequencer one round
//   key_out/valid/round registered read result (1-cycle latency)
//   seq_last           final round of a sequence delivered
//   keys_loaded        store full, reads permitted
//   rd_err             illegal read pulse
//   key_err            parity error pulse
module aes_round_key_store #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 15,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              seq_start,
  input  logic              seq_dir,
  input  logic              seq_step,
  output logic [DATA_W-1:0] key_out,
  output logic              key_valid,
  output logic [ADDR_W-1:0] key_round,
  output logic              seq_last,
  output logic              keys_loaded,
  output logic              rd_err,
  output logic              key_err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_FULL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_fire;
  logic              full;

  logic [DATA_W-1:0] mem [DEPTH];

  // clear wins over a same-cycle beat: the beat is dropped.
  assign wr_fire = wr_valid & wr_ready & ~clear;
  assign full    = (state == S_FULL);

  // ---------------- load FSM ----------------
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) state_nxt = S_EMPTY;
    else begin
      case (state)
        S_EMPTY: if (wr_fire) state_nxt = (DEPTH == 1) ? S_FULL : S_LOAD;
        S_LOAD:  if (wr_fire && wr_ptr == LAST) state_nxt = S_FULL;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ready    = 1'b0;
    keys_loaded = 1'b0;
    case (state)
      S_EMPTY, S_LOAD: wr_ready    = 1'b1;
      S_FULL:          keys_loaded = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) wr_ptr <= '0;
    else if (wr_fire)     wr_ptr <= wr_ptr + 1'b1;
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (resetn && wr_fire) mem[wr_ptr] <= wr_data;
  end

  // ---------------- round sequencer ----------------
  logic              seq_act, seq_rev;
  logic [ADDR_W-1:0] seq_ptr, seq_end, seq_nxt, start_idx;
  logic              at_end;

  assign seq_end   = seq_rev ? '0 : LAST;
  assign seq_nxt   = seq_rev ? seq_ptr - 1'b1 : seq_ptr + 1'b1;
  assign at_end    = (seq_ptr == seq_end);
  assign start_idx = seq_dir ? LAST : '0;

  // seq_act stays set while the last key sits delivered; the following step
  // just retires the sequence without producing a key.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      seq_act <= 1'b0;
      seq_rev <= 1'b0;
      seq_ptr <= '0;
    end else if (seq_start && full) begin
      seq_act <= 1'b1;
      seq_rev <= seq_dir;
      seq_ptr <= start_idx;
    end else if (seq_step && full && seq_act) begin
      if (at_end) seq_act <= 1'b0;
      else        seq_ptr <= seq_nxt;
    end
  end

  // ---------------- request arbitration ----------------
  // clear > seq_start > seq_step > rd_en; only the winner is acted on.
  logic              do_rd, do_err, rd_last;
  logic [ADDR_W-1:0] rd_idx;

  always_comb begin
    do_rd   = 1'b0;
    do_err  = 1'b0;
    rd_last = 1'b0;
    rd_idx  = '0;
    if (clear) begin
      do_rd = 1'b0;
    end else if (seq_start) begin
      if (full) begin
        do_rd   = 1'b1;
        rd_idx  = start_idx;
        rd_last = (DEPTH == 1);
      end else begin
        do_err = 1'b1;
      end
    end else if (seq_step) begin
      if (!full) do_err = 1'b1;
      else if (seq_act && !at_end) begin
        do_rd   = 1'b1;
        rd_idx  = seq_nxt;
        rd_last = (seq_nxt == seq_end);
      end
    end else if (rd_en) begin
      if (!full || int'(rd_addr) >= DEPTH) do_err = 1'b1;
      else begin
        do_rd  = 1'b1;
        rd_idx = rd_addr;
      end
    end
  end

  // ---------------- read output registers ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_out   <= '0;
      key_round <= '0;
      key_valid <= 1'b0;
      seq_last  <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      key_valid <= do_rd;
      seq_last  <= do_rd & rd_last;
      rd_err    <= do_err;
      if (do_rd) begin
        key_out   <= mem[rd_idx];
        key_round <= rd_idx;
      end
    end
  end

`ifdef KEYSTORE_PARITY_EN
  localparam int NB = DATA_W / 8;

  logic [NB-1:0] par_mem [DEPTH];
  logic          perr;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^d[b*8 +: 8];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (resetn && wr_fire) par_mem[wr_ptr] <= byte_par(wr_data);
  end

  assign perr = |(byte_par(mem[rd_idx]) ^ par_mem[rd_idx]);

  always_ff @(posedge clk) begin
    if (!resetn) key_err <= 1'b0;
    else         key_err <= do_rd & perr;
  end
`else
  assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_key_store.sv
module tb_aes_round_key_store;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         wr_valid = 1'b0, clear = 1'b0, rd_en = 1'b0;
  logic         seq_start = 1'b0, seq_dir = 1'b0, seq_step = 1'b0;
  logic [127:0] wr_data = '0;
  logic [3:0]   rd_addr = '0;
  logic         wr_ready, key_valid, seq_last, keys_loaded, rd_err, key_err;
  logic [127:0] key_out;
  logic [3:0]   key_round;

  int n_vec = 0;
  int n_err = 0;

  aes_round_key_store dut (
    .clk(clk), .resetn(resetn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .seq_start(seq_start), .seq_dir(seq_dir), .seq_step(seq_step),
    .key_out(key_out), .key_valid(key_valid), .key_round(key_round),
    .seq_last(seq_last), .keys_loaded(keys_loaded),
    .rd_err(rd_err), .key_err(key_err)
  );

  always #5 clk = ~clk;

  // {key_valid, seq_last, rd_err, key_err, keys_loaded, wr_ready}
  wire [5:0] flags = {key_valid, seq_last, rd_err, key_err, keys_loaded, wr_ready};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] kv(input logic [7:0] base, input int i);
    logic [7:0] b;
    b = base + 8'(i);
    return {16{b}};
  endfunction

  task automatic test_reset;
    resetn = 1'b0;
    tick; tick;
    n_vec++; if (flags !== 6'b000001) begin n_err++; $display("FAIL reset_flags got %b want 000001", flags); end
    n_vec++; if (key_out !== '0 || key_round !== '0) begin n_err++; $display("FAIL reset_key got %h/%0d want 0/0", key_out, key_round); end
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_load;
    for (int i = 0; i < 15; i++) begin
      if (i == 6) begin wr_valid = 1'b0; wr_data = '1; tick; end
      wr_valid = 1'b1;
      wr_data  = kv(8'h10, i);
      n_vec++; if (wr_ready !== 1'b1 || keys_loaded !== 1'b0) begin n_err++; $display("FAIL load_ready beat %0d got rdy=%b ld=%b want 1/0", i, wr_ready, keys_loaded); end
      tick;
    end
    wr_data = '1;
    n_vec++; if (flags !== 6'b000010) begin n_err++; $display("FAIL load_full got %b want 000010", flags); end
    tick;
    n_vec++; if (flags !== 6'b000010) begin n_err++; $display("FAIL load_16th got %b want 000010", flags); end
    wr_valid = 1'b0;
    tick;
  endtask

  task automatic test_seq_fwd;
    seq_dir = 1'b0; seq_start = 1'b1;
    tick;
    seq_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      n_vec++; if ({key_valid, seq_last, rd_err} !== {1'b1, 1'(i == 14), 1'b0} || key_round !== 4'(i) || key_out !== kv(8'h10, i)) begin
        n_err++; $display("FAIL fwd_round %0d got v=%b l=%b e=%b r=%0d k=%h", i, key_valid, seq_last, rd_err, key_round, key_out);
      end
      seq_step = 1'b1;
      tick;
    end
    seq_step = 1'b0;
    n_vec++; if (key_valid !== 1'b0 || rd_err !== 1'b0 || key_out !== kv(8'h10, 14)) begin n_err++; $display("FAIL fwd_end got v=%b e=%b k=%h", key_valid, rd_err, key_out); end
    tick;
  endtask

  task automatic test_seq_rev;
    seq_dir = 1'b1; seq_start = 1'b1; rd_en = 1'b1; rd_addr = 4'd3;
    tick;
    seq_start = 1'b0; rd_en = 1'b0; seq_dir = 1'b0;
    for (int i = 0; i < 15; i++) begin
      n_vec++; if ({key_valid, seq_last, rd_err} !== {1'b1, 1'(i == 14), 1'b0} || key_round !== 4'(14 - i) || key_out !== kv(8'h10, 14 - i)) begin
        n_err++; $display("FAIL rev_round %0d got v=%b l=%b e=%b r=%0d k=%h", 14 - i, key_valid, seq_last, rd_err, key_round, key_out);
      end
      seq_step = 1'b1;
      tick;
    end
    n_vec++; if (key_valid !== 1'b0 || rd_err !== 1'b0) begin n_err++; $display("FAIL rev_end got v=%b e=%b want 0/0", key_valid, rd_err); end
    tick;
    n_vec++; if (key_valid !== 1'b0 || rd_err !== 1'b0) begin n_err++; $display("FAIL idle_step got v=%b e=%b want 0/0", key_valid, rd_err); end
    seq_step = 1'b0;
  endtask

  task automatic test_rd_err;
    rd_en = 1'b1; rd_addr = 4'd15;
    tick;
    n_vec++; if (key_valid !== 1'b0 || rd_err !== 1'b1 || key_out !== kv(8'h10, 0)) begin n_err++; $display("FAIL rd_oob got v=%b e=%b k=%h", key_valid, rd_err, key_out); end
    rd_addr = 4'd7;
    tick;
    n_vec++; if (flags !== 6'b100010 || key_round !== 4'd7 || key_out !== kv(8'h10, 7)) begin n_err++; $display("FAIL rd_7 got %b r=%0d k=%h", flags, key_round, key_out); end
    rd_en = 1'b0;
    tick;
    n_vec++; if (flags !== 6'b000010 || key_out !== kv(8'h10, 7)) begin n_err++; $display("FAIL rd_hold got %b k=%h", flags, key_out); end
  endtask

  task automatic test_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    n_vec++; if (flags !== 6'b000001) begin n_err++; $display("FAIL clear got %b want 000001", flags); end
    rd_en = 1'b1; rd_addr = 4'd2;
    tick;
    rd_en = 1'b0;
    n_vec++; if (flags !== 6'b001001 || key_out !== kv(8'h10, 7)) begin n_err++; $display("FAIL rd_empty got %b k=%h", flags, key_out); end
    seq_start = 1'b1;
    tick;
    seq_start = 1'b0;
    n_vec++; if (flags !== 6'b001001) begin n_err++; $display("FAIL seq_empty got %b want 001001", flags); end
    tick;
    n_vec++; if (flags !== 6'b000001) begin n_err++; $display("FAIL err_pulse got %b want 000001", flags); end
  endtask

  task automatic test_clear_drop;
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1; wr_data = kv(8'h40, i);
      tick;
    end
    wr_data = kv(8'h40, 7); clear = 1'b1;
    tick;
    clear = 1'b0; wr_valid = 1'b0;
    n_vec++; if (flags !== 6'b000001) begin n_err++; $display("FAIL clear_wr got %b want 000001", flags); end
    for (int i = 0; i < 15; i++) begin
      wr_valid = 1'b1; wr_data = kv(8'h40, i);
      tick;
      if (i == 13) begin
        n_vec++; if (flags !== 6'b000001) begin n_err++; $display("FAIL reload_14 got %b want 000001", flags); end
      end
    end
    wr_valid = 1'b0;
    n_vec++; if (flags !== 6'b000010) begin n_err++; $display("FAIL reload_full got %b want 000010", flags); end
    for (int a = 0; a < 15; a += 7) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      tick;
      n_vec++; if (flags !== 6'b100010 || key_round !== 4'(a) || key_out !== kv(8'h40, a)) begin n_err++; $display("FAIL reload_rd %0d got %b k=%h", a, flags, key_out); end
    end
    rd_en = 1'b0;
    tick;
  endtask

`ifdef KEYSTORE_PARITY_EN
  task automatic test_parity;
    dut.mem[3][0] = ~dut.mem[3][0];
    rd_en = 1'b1; rd_addr = 4'd3;
    tick;
    n_vec++; if (key_valid !== 1'b1 || key_err !== 1'b1 || key_out !== (kv(8'h40, 3) ^ 128'h1)) begin n_err++; $display("FAIL par_bad got v=%b pe=%b k=%h", key_valid, key_err, key_out); end
    rd_addr = 4'd4;
    tick;
    n_vec++; if (key_valid !== 1'b1 || key_err !== 1'b0) begin n_err++; $display("FAIL par_ok got v=%b pe=%b want 1/0", key_valid, key_err); end
    rd_en = 1'b0;
    tick;
  endtask
`endif

  task automatic test_reset_mid;
    seq_dir = 1'b0; seq_start = 1'b1;
    tick;
    seq_start = 1'b0; seq_step = 1'b1;
    tick;
    n_vec++; if (key_valid !== 1'b1 || key_round !== 4'd1) begin n_err++; $display("FAIL mid_seq got v=%b r=%0d want 1/1", key_valid, key_round); end
    resetn = 1'b0;
    tick;
    n_vec++; if (flags !== 6'b000001 || key_out !== '0 || key_round !== '0) begin n_err++; $display("FAIL mid_reset got %b k=%h r=%0d", flags, key_out, key_round); end
    resetn = 1'b1;
    tick;
    n_vec++; if (flags !== 6'b001001) begin n_err++; $display("FAIL post_reset_step got %b want 001001", flags); end
    seq_step = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_load;
    test_seq_fwd;
    test_seq_rev;
    test_rd_err;
    test_clear;
    test_clear_drop;
`ifdef KEYSTORE_PARITY_EN
    test_parity;
`endif
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
